mm4x4_stream_io: RTL and testbench

Streaming I/O stage wrapped around the combinational 4x4 signed matrix multiplier (w-bit operands, 2w+2-bit results). It collects A and B elements from a valid/ready input stream, holds the assembled matrices stable on the multiplier inputs, and captures the 16 products into a result buffer after a fixed settle time. It then returns the results as a valid/ready output stream. Loading of the next matrix pair overlaps with unloading of the previous result.

---
 rtl/mm4x4_stream_io_if.sv | 25 ++
 rtl/mm4x4_stream_io.sv | 96 +++++++++
 tb/tb_mm4x4_stream_io.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mm4x4_stream_io_if.sv
// Load and unload streams of the 4x4 matrix-multiply I/O stage.
// The slave modport is the stage's view, the master modport is the producer/consumer view.
interface mm4x4_stream_io_if #(
  parameter int w         = 8,
  parameter int WIDTH_OUT = 2*w+2
);
  logic                 in_valid;
  logic                 in_ready;
  logic [w-1:0]         in_a;
  logic [w-1:0]         in_b;
  logic                 out_valid;
  logic                 out_ready;
  logic [WIDTH_OUT-1:0] out_c;
  logic                 out_last;

  modport slave (
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_c, out_last
  );

  modport master (
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_c, out_last
  );
endinterface

// File: rtl/mm4x4_stream_io.sv
// Streaming I/O stage around a combinational 4x4 signed matrix multiplier: assembles A/B from a
// beat stream, holds them for SETTLE cycles, captures C into a buffer and streams C back out.
module mm4x4_stream_io #(
  parameter int w         = 8,
  parameter int WIDTH_OUT = 2*w+2,
  parameter int SETTLE    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  mm4x4_stream_io_if.slave          io,
  output logic [16*w-1:0]           mat_a,
  output logic [16*w-1:0]           mat_b,
  input  logic [16*WIDTH_OUT-1:0]   mat_c,
  output logic                      busy
);
  localparam int CNT_W = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE - 1);

  typedef enum logic [1:0] {S_LOAD, S_SETTLE, S_WAIT_CAP} state_e;

  state_e                      state_q;
  logic [3:0]                  idx_q;
  logic [3:0]                  oidx_q;
  logic [CNT_W-1:0]            cnt_q;
  logic                        c_full_q;
  logic signed [w-1:0]         a_q [16];
  logic signed [w-1:0]         b_q [16];
  logic signed [WIDTH_OUT-1:0] c_q [16];

  logic in_fire;
  logic out_fire;
  logic last_fire;
  logic capture;

  assign io.in_ready = (state_q == S_LOAD);
  assign in_fire     = io.in_valid && io.in_ready;
  assign out_fire    = c_full_q && io.out_ready;
  assign last_fire   = out_fire && (oidx_q == 4'd15);
  // The final unload beat frees the buffer in the same cycle, so a waiting result can land at once.
  assign capture     = (state_q == S_WAIT_CAP) && (!c_full_q || last_fire);

  assign io.out_valid = c_full_q;
  assign io.out_c     = c_q[oidx_q];
  assign io.out_last  = c_full_q && (oidx_q == 4'd15);
  assign busy         = (idx_q != 4'd0) || (state_q != S_LOAD) || c_full_q;

  for (genvar g = 0; g < 16; g++) begin : g_pack
    assign mat_a[g*w +: w] = a_q[g];
    assign mat_b[g*w +: w] = b_q[g];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_LOAD;
      idx_q    <= 4'd0;
      oidx_q   <= 4'd0;
      cnt_q    <= '0;
      c_full_q <= 1'b0;
      for (int k = 0; k < 16; k++) begin
        a_q[k] <= '0;
        b_q[k] <= '0;
        c_q[k] <= '0;
      end
    end else begin
      unique case (state_q)
        S_LOAD: begin
          if (in_fire) begin
            a_q[idx_q] <= io.in_a;
            b_q[idx_q] <= io.in_b;
            idx_q      <= idx_q + 4'd1;
            if (idx_q == 4'd15) begin
              state_q <= S_SETTLE;
              cnt_q   <= '0;
            end
          end
        end
        S_SETTLE: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == CNT_LAST) state_q <= S_WAIT_CAP;
        end
        S_WAIT_CAP: begin
          if (capture) begin
            for (int k = 0; k < 16; k++) c_q[k] <= mat_c[k*WIDTH_OUT +: WIDTH_OUT];
            state_q <= S_LOAD;
          end
        end
        default: state_q <= S_LOAD;
      endcase

      if (out_fire) oidx_q <= oidx_q + 4'd1;

      if (capture)        c_full_q <= 1'b1;
      else if (last_fire) c_full_q <= 1'b0;
    end
  end
endmodule

// File: tb/tb_mm4x4_stream_io.sv
// Bench for mm4x4_stream_io: directed latency/back-pressure/reset sequences, a constant-fill
// vector table, and randomized valid/ready traffic against a software matrix-product model.
module tb_mm4x4_stream_io;
  localparam int W  = 8;
  localparam int WO = 2*W+2;
  localparam int NRAND = 500;

  typedef logic signed [W-1:0] mat_t [16];
  typedef int res_t [16];
  typedef struct {
    logic signed [W-1:0] a;
    logic signed [W-1:0] b;
    int                  c;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [16*W-1:0]  mat_a;
  logic [16*W-1:0]  mat_b;
  logic [16*WO-1:0] mat_c;
  logic             busy;

  int checks = 0;
  int failures = 0;
  int exp_q [$];

  mm4x4_stream_io_if #(.w(W), .WIDTH_OUT(WO)) io ();

  mm4x4_stream_io #(.w(W), .WIDTH_OUT(WO), .SETTLE(1)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (io),
    .mat_a (mat_a),
    .mat_b (mat_b),
    .mat_c (mat_c),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  // Stand-in for the external combinational multiplier.
  function automatic logic [16*WO-1:0] mm(input logic [16*W-1:0] a, input logic [16*W-1:0] b);
    logic [16*WO-1:0] r;
    int acc;
    r = '0;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        acc = 0;
        for (int k = 0; k < 4; k++)
          acc += int'($signed(a[(4*i+k)*W +: W])) * int'($signed(b[(4*k+j)*W +: W]));
        r[(4*i+j)*WO +: WO] = acc[WO-1:0];
      end
    return r;
  endfunction

  assign mat_c = mm(mat_a, mat_b);

  function automatic void ref_mult(input mat_t a, input mat_t b, output res_t c);
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++) begin
        c[4*i+j] = 0;
        for (int k = 0; k < 4; k++) c[4*i+j] += int'(a[4*i+k]) * int'(b[4*k+j]);
      end
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  task automatic abort(input string name);
    checks++;
    failures++;
    $display("FAIL %s: got timeout, want DUT handshake", name);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  endtask

  task automatic rand_mat(output mat_t m);
    for (int k = 0; k < 16; k++) m[k] = W'($urandom);
  endtask

  // Called at posedge+1; returns at posedge+1 just after the last accepted beat.
  task automatic load(input mat_t a, input mat_t b, input int nbeats, input bit gaps);
    for (int k = 0; k < nbeats; k++) begin
      int  n;
      bit  acc;
      if (gaps) begin
        while ($urandom_range(3) == 0) begin
          io.in_valid = 1'b0;
          io.in_a = W'($urandom);
          io.in_b = W'($urandom);
          @(posedge clk); #1;
        end
      end
      io.in_valid = 1'b1;
      io.in_a = a[k];
      io.in_b = b[k];
      n = 0;
      acc = 1'b0;
      while (!acc) begin
        @(negedge clk);
        acc = io.in_ready;
        @(posedge clk); #1;
        n++;
        if (!acc && n > 3000) abort("load_wait");
      end
    end
    io.in_valid = 1'b0;
  endtask

  // Unload one 16-beat result; in rnd mode out_ready is randomized and expected values come from exp_q.
  task automatic unload(input res_t exp, input string tag, input bit strict, input bit rnd);
    for (int b = 0; b < 16; b++) begin
      int n;
      int e;
      n = 0;
      while (1) begin
        io.out_ready = rnd ? ($urandom_range(3) != 0) : 1'b1;
        @(negedge clk);
        if (io.out_valid && io.out_ready) break;
        @(posedge clk); #1;
        n++;
        if (n > 5000) abort({tag, "_wait"});
      end
      if (!rnd && (strict || b > 0)) chk({tag, "_gap"}, n, 0);
      if (rnd) begin
        if (exp_q.size() == 0) abort({tag, "_extra_beat"});
        e = exp_q.pop_front();
      end else begin
        e = exp[b];
      end
      chk({tag, "_c"}, longint'($signed(io.out_c)), e);
      chk({tag, "_last"}, longint'(io.out_last), (b == 15) ? 1 : 0);
      @(posedge clk); #1;
    end
    io.out_ready = 1'b0;
  endtask

  task automatic wait_valid(input string tag);
    int n;
    n = 0;
    @(negedge clk);
    while (!io.out_valid) begin
      @(posedge clk); #1;
      @(negedge clk);
      n++;
      if (n > 100) abort(tag);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl [7];
    mat_t a, b, p1a, p1b, p2a, p2b;
    res_t e, e1, e2;

    tbl[0] = '{a: -8'sd128, b: -8'sd128, c: 65536};
    tbl[1] = '{a:  8'sd127, b: -8'sd128, c: -65024};
    tbl[2] = '{a:  8'sd127, b:  8'sd127, c: 64516};
    tbl[3] = '{a: -8'sd128, b:  8'sd127, c: -65024};
    tbl[4] = '{a:  8'sd0,   b:  8'sd55,  c: 0};
    tbl[5] = '{a:  8'sd1,   b:  8'sd1,   c: 4};
    tbl[6] = '{a: -8'sd1,   b:  8'sd3,   c: -12};

    io.in_valid = 1'b0;
    io.in_a = '0;
    io.in_b = '0;
    io.out_ready = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    @(negedge clk);
    chk("rst_in_ready", longint'(io.in_ready), 1);
    chk("rst_out_valid", longint'(io.out_valid), 0);
    chk("rst_out_last", longint'(io.out_last), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_out_c", longint'(io.out_c), 0);
    chk("rst_mat_a", longint'(|mat_a), 0);
    chk("rst_mat_b", longint'(|mat_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Identity x ramp, with exact capture latency.
    for (int k = 0; k < 16; k++) begin
      a[k] = ((k / 4) == (k % 4)) ? 8'sd1 : 8'sd0;
      b[k] = W'(k);
      e[k] = k;
    end
    load(a, b, 16, 1'b0);
    @(negedge clk);
    chk("lat_t0_in_ready", longint'(io.in_ready), 0);
    chk("lat_t0_out_valid", longint'(io.out_valid), 0);
    chk("lat_t0_busy", longint'(busy), 1);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_t1_in_ready", longint'(io.in_ready), 0);
    chk("lat_t1_out_valid", longint'(io.out_valid), 0);
    @(posedge clk); #1;
    @(negedge clk);
    chk("lat_t2_in_ready", longint'(io.in_ready), 1);
    chk("lat_t2_out_valid", longint'(io.out_valid), 1);
    @(posedge clk); #1;
    unload(e, "ident", 1'b1, 1'b0);

    for (int t = 0; t < 7; t++) begin
      for (int k = 0; k < 16; k++) begin
        a[k] = tbl[t].a;
        b[k] = tbl[t].b;
        e[k] = tbl[t].c;
      end
      load(a, b, 16, 1'b0);
      unload(e, $sformatf("tbl%0d", t), 1'b0, 1'b0);
    end

    // Back-pressure: second pair stalls until the first result drains, then is captured on its last beat.
    rand_mat(p1a); rand_mat(p1b); ref_mult(p1a, p1b, e1);
    rand_mat(p2a); rand_mat(p2b); ref_mult(p2a, p2b, e2);
    io.out_ready = 1'b0;
    load(p1a, p1b, 16, 1'b0);
    wait_valid("bp_first_valid");
    load(p2a, p2b, 16, 1'b0);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      chk("bp_in_ready", longint'(io.in_ready), 0);
      chk("bp_out_valid", longint'(io.out_valid), 1);
      chk("bp_hold_c", longint'($signed(io.out_c)), e1[0]);
      chk("bp_busy", longint'(busy), 1);
      @(posedge clk); #1;
    end
    unload(e1, "bp_r1", 1'b1, 1'b0);
    unload(e2, "bp_r2", 1'b1, 1'b0);
    @(negedge clk);
    chk("bp_done_valid", longint'(io.out_valid), 0);
    chk("bp_done_in_ready", longint'(io.in_ready), 1);
    @(posedge clk); #1;

    // Reset with a result undelivered and a partial load in progress.
    load(p1a, p1b, 16, 1'b0);
    wait_valid("rst_first_valid");
    load(p2a, p2b, 7, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst_in_ready", longint'(io.in_ready), 1);
    chk("mrst_out_valid", longint'(io.out_valid), 0);
    chk("mrst_out_last", longint'(io.out_last), 0);
    chk("mrst_busy", longint'(busy), 0);
    chk("mrst_out_c", longint'(io.out_c), 0);
    chk("mrst_mat_a", longint'(|mat_a), 0);
    chk("mrst_mat_b", longint'(|mat_b), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    load(p2a, p2b, 16, 1'b0);
    unload(e2, "mrst_after", 1'b0, 1'b0);

    // Randomized traffic over many matrix pairs.
    fork
      begin
        mat_t ra, rb;
        res_t rc;
        for (int p = 0; p < NRAND; p++) begin
          rand_mat(ra);
          rand_mat(rb);
          ref_mult(ra, rb, rc);
          for (int k = 0; k < 16; k++) exp_q.push_back(rc[k]);
          load(ra, rb, 16, 1'b1);
        end
      end
      begin
        res_t dummy;
        for (int k = 0; k < 16; k++) dummy[k] = 0;
        for (int p = 0; p < NRAND; p++) unload(dummy, "rnd", 1'b0, 1'b1);
      end
    join

    @(negedge clk);
    chk("end_busy", longint'(busy), 0);
    chk("end_out_valid", longint'(io.out_valid), 0);
    chk("end_exp_left", longint'(exp_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
